pipo_arb: RTL and testbench

Round-robin write arbiter and sequencer for a shared W-bit parallel-in/parallel-out register. Up to N requesters compete to load the register through a req/ack handshake. A dedicated clear request zeroes it. The block owns the register and presents its contents on `q`, so downstream logic sees one clean registered value with a single writer.

---
 rtl/pipo_arb_pkg.sv | 20 ++
 rtl/pipo_arb_pick.sv | 30 +++
 rtl/pipo_arb.sv | 130 +++++++++++++
 tb/tb_pipo_arb.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipo_arb_pkg.sv
// pipo_arb_pkg: shared constants for the pipo_arb write arbiter.
//   IDLE/BUSY      : FSM state encoding
//   N_DEF / W_DEF  : default requester count and register width
//   STATS_MAX      : saturation value of the optional write counter
//   sat_inc8()     : saturating 8-bit increment used by the write counter
package pipo_arb_pkg;

    localparam logic IDLE = 1'b0;
    localparam logic BUSY = 1'b1;

    localparam int N_DEF = 4;
    localparam int W_DEF = 4;

    localparam logic [7:0] STATS_MAX = 8'd255;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == STATS_MAX) ? v : (v + 8'd1);
    endfunction

endpackage

// File: rtl/pipo_arb_pick.sv
// rr_pick: purely combinational round-robin winner selection.
//   req     : N request bits
//   ptr     : index where the scan starts (highest priority)
//   win_idx : first set request found scanning ptr, ptr+1, ... modulo N
//   win_vld : high when any request is set
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] win_idx,
    output logic          win_vld
);

    // Scan from the farthest offset back to offset 0 so the nearest set bit is kept last.
    always_comb begin
        int          idx_i;
        logic [PW-1:0] idx_s;
        win_idx = '0;
        win_vld = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            idx_i   = (int'(ptr) + k) % N;
            idx_s   = PW'(idx_i);
            win_idx = req[idx_s] ? idx_s : win_idx;
            win_vld = win_vld | req[idx_s];
        end
    end

endmodule

// File: rtl/pipo_arb.sv
// pipo_arb: round-robin write arbiter owning a W-bit parallel register.
//   clk      : clock, rising edge
//   clr      : asynchronous active-high reset
//   req      : per-requester write request, held until ack
//   d        : flat write data, requester i on d[i*W +: W]
//   clr_req  : request to zero the register (beats writes in IDLE)
//   ack      : one-hot write acknowledge, high during the BUSY cycle
//   clr_ack  : one-cycle clear acknowledge (registered)
//   q        : register contents (registered)
//   busy     : high while in BUSY
//   gnt_idx  : current or last grantee (registered)
//   wr_cnt   : saturating count of completed writes, only when
//              PIPO_ARB_STATS_EN is defined
module pipo_arb
    import pipo_arb_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       d,
    input  logic                 clr_req,
    output logic [N-1:0]         ack,
    output logic                 clr_ack,
    output logic [W-1:0]         q,
    output logic                 busy,
    output logic [$clog2(N)-1:0] gnt_idx
`ifdef PIPO_ARB_STATS_EN
    ,
    output logic [7:0]           wr_cnt
`endif
);

    localparam int PW = $clog2(N);

    logic          state_r;
    logic [PW-1:0] ptr_r;
    logic [PW-1:0] gnt_r;
    logic [W-1:0]  q_r;
    logic          clr_ack_r;

    logic [PW-1:0] win_idx_s;
    logic          win_vld_s;
    logic [W-1:0]  sel_d_s;
    logic [N-1:0]  ack_s;
    logic [PW-1:0] ptr_nxt_s;

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_r),
        .win_idx (win_idx_s),
        .win_vld (win_vld_s)
    );

    // Grantee data mux and ack decode; ack depends only on registered state.
    always_comb begin
        sel_d_s = '0;
        ack_s   = '0;
        for (int i = 0; i < N; i++) begin
            sel_d_s  = (gnt_r == PW'(i)) ? d[i*W +: W] : sel_d_s;
            ack_s[i] = (state_r == BUSY) && (gnt_r == PW'(i));
        end
    end

    // Pointer moves just past the grantee, wrapping at N-1 (N need not be a power of two).
    assign ptr_nxt_s = (gnt_r == PW'(N - 1)) ? '0 : (gnt_r + PW'(1));

    // Arbitration FSM and register ownership.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r   <= IDLE;
            ptr_r     <= '0;
            gnt_r     <= '0;
            q_r       <= '0;
            clr_ack_r <= 1'b0;
        end else begin
            clr_ack_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (clr_req) begin
                        q_r       <= '0;
                        clr_ack_r <= 1'b1;
                    end else if (win_vld_s) begin
                        gnt_r   <= win_idx_s;
                        state_r <= BUSY;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    q_r     <= sel_d_s;
                    ptr_r   <= ptr_nxt_s;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef PIPO_ARB_STATS_EN
    logic [7:0] wr_cnt_r;

    // Completed-write counter: one step per BUSY cycle, saturating.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_cnt_r <= 8'd0;
        end else if (state_r == BUSY) begin
            wr_cnt_r <= sat_inc8(wr_cnt_r);
        end else begin
            wr_cnt_r <= wr_cnt_r;
        end
    end

    assign wr_cnt = wr_cnt_r;
`endif

    assign ack     = ack_s;
    assign busy    = (state_r == BUSY);
    assign q       = q_r;
    assign clr_ack = clr_ack_r;
    assign gnt_idx = gnt_r;

endmodule

// File: tb/tb_pipo_arb.sv
// tb_pipo_arb: scoreboard bench for pipo_arb (N=4, W=4).
// The driver runs a transaction-level model and queues expected events;
// an independent monitor pops and checks them whenever ack/clr_ack appear.
module tb_pipo_arb;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int DW = N * W;

    logic          clk = 1'b0;
    logic          clr;
    logic [N-1:0]  req;
    logic [DW-1:0] d;
    logic          clr_req;
    logic [N-1:0]  ack;
    logic          clr_ack;
    logic [W-1:0]  q;
    logic          busy;
    logic [1:0]    gnt_idx;
`ifdef PIPO_ARB_STATS_EN
    logic [7:0]    wr_cnt;
`endif

    pipo_arb #(.N(N), .W(W)) dut (
        .clk     (clk),
        .clr     (clr),
        .req     (req),
        .d       (d),
        .clr_req (clr_req),
        .ack     (ack),
        .clr_ack (clr_ack),
        .q       (q),
        .busy    (busy),
        .gnt_idx (gnt_idx)
`ifdef PIPO_ARB_STATS_EN
        ,
        .wr_cnt  (wr_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           is_clr;
        int           idx;
        logic [W-1:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  obs_q[$];

    int total = 0;
    int bad   = 0;

    // reference model state
    int m_ptr  = 0;
    int m_gnt  = 0;
    int m_done = -1;
    int m_wr   = 0;
    bit m_busy = 1'b0;

    // monitor state
    logic [W-1:0] cur_q_exp = '0;
    logic [W-1:0] pend_val  = '0;
    bit           pend      = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_gnt  = 0;
        m_done = -1;
        m_wr   = 0;
        m_busy = 1'b0;
        exp_q.delete();
    endtask

    // Apply one cycle of inputs; the model decides what this cycle's edge must produce.
    task automatic drive(input logic [N-1:0] r, input logic [DW-1:0] dv, input logic c);
        ev_t e;
        logic [N-1:0] sh;
        req     = r;
        d       = dv;
        clr_req = c;
        if (m_busy) begin
            e.is_clr = 1'b0;
            e.idx    = m_gnt;
            e.data   = W'(dv >> (m_gnt * W));
            exp_q.push_back(e);
            m_ptr  = (m_gnt + 1) % N;
            m_done = m_gnt;
            m_busy = 1'b0;
            m_wr++;
        end else if (c) begin
            e.is_clr = 1'b1;
            e.idx    = 0;
            e.data   = '0;
            exp_q.push_back(e);
        end else if (r != '0) begin
            for (int k = 0; k < N; k++) begin
                sh = r >> ((m_ptr + k) % N);
                if (sh[0]) begin
                    m_gnt = (m_ptr + k) % N;
                    break;
                end
            end
            m_busy = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: checks q every cycle and consumes expected events on ack/clr_ack.
    initial begin
        ev_t e;
        int  ai;
        forever begin
            @(negedge clk);
            if (clr) begin
                cur_q_exp = '0;
                pend      = 1'b0;
            end else begin
                if (pend) begin
                    cur_q_exp = pend_val;
                    pend      = 1'b0;
                end
                if (clr_ack) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_clr_ack", 32'(clr_ack), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("clr_event_kind", 32'(e.is_clr), 32'd1);
                        cur_q_exp = '0;
                    end
                end
                chk("q", 32'(q), 32'(cur_q_exp));
                if (ack != '0) begin
                    chk("busy_high", 32'(busy), 32'd1);
                    ai = -1;
                    for (int i = 0; i < N; i++) begin
                        if (ack[i]) ai = i;
                    end
                    obs_q.push_back(ai);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_ack", 32'(ack), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ack_event_kind", 32'(e.is_clr), 32'd0);
                        chk("ack_onehot", 32'(ack), 32'd1 << e.idx);
                        chk("gnt_idx", 32'(gnt_idx), 32'(e.idx));
                        pend     = 1'b1;
                        pend_val = e.data;
                    end
                end else begin
                    chk("busy_low", 32'(busy), 32'd0);
                end
            end
        end
    end

    // Stimulus
    initial begin
        logic [N-1:0]  r;
        logic [N-1:0]  bitm;
        logic [DW-1:0] dv;
        logic [DW-1:0] fm;
        logic [DW-1:0] nv;
        int exp_order[14] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2, 0, 1, 3, 2};

        clr     = 1'b1;
        req     = '0;
        d       = '0;
        clr_req = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_q", 32'(q), 32'd0);
        chk("reset_ack", 32'(ack), 32'd0);
        chk("reset_clr_ack", 32'(clr_ack), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_gnt_idx", 32'(gnt_idx), 32'd0);
        clr = 1'b0;

        // reset in the middle of a write by requester 2
        drive(4'b0100, 16'h0A00, 1'b0);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        clr = 1'b1;
        model_reset();
        #1;
        chk("midbusy_reset_q", 32'(q), 32'd0);
        chk("midbusy_reset_ack", 32'(ack), 32'd0);
        chk("midbusy_reset_busy", 32'(busy), 32'd0);
        req = '0;
        @(posedge clk);
        #1;
        clr = 1'b0;
        repeat (4) drive(4'b0000, 16'h0000, 1'b0);
        obs_q.delete();

        // fairness: all requests held, distinct data
        repeat (16) drive(4'b1111, 16'h4321, 1'b0);
        // after requester 3, only requester 0
        repeat (2) drive(4'b0001, 16'h4321, 1'b0);
        // requester 2 alone leaves ptr at 3
        repeat (2) drive(4'b0100, 16'h0600, 1'b0);
        // wrap: scan from 3 must pick 0 before 1
        repeat (2) drive(4'b0011, 16'h005C, 1'b0);
        // single write by requester 1
        repeat (2) drive(4'b0010, 16'h0050, 1'b0);
        // load 4'hF then clear together with req[2]
        repeat (2) drive(4'b1000, 16'hF000, 1'b0);
        drive(4'b0100, 16'h0700, 1'b1);
        repeat (2) drive(4'b0100, 16'h0700, 1'b0);
        drive(4'b0000, 16'h0700, 1'b0);

        chk("order_len", 32'(obs_q.size()), 32'd14);
        for (int i = 0; i < 14; i++) begin
            if (i < obs_q.size()) chk("grant_order", 32'(obs_q[i]), 32'(exp_order[i]));
        end

        // randomized traffic that follows the requester rule
        m_done = -1;
        for (int s = 0; s < 1500; s++) begin
            r  = req;
            dv = d;
            for (int i = 0; i < N; i++) begin
                bitm = N'(1) << i;
                fm   = DW'(4'hF) << (i * W);
                nv   = DW'($urandom_range(15)) << (i * W);
                if (i == m_done) begin
                    if ($urandom_range(3) != 0) r = r & ~bitm;
                    else dv = (dv & ~fm) | nv;
                end else if ((r & bitm) == '0 && $urandom_range(2) == 0) begin
                    r  = r | bitm;
                    dv = (dv & ~fm) | nv;
                end
            end
            m_done = -1;
            drive(r, dv, ($urandom_range(7) == 0));
        end

        // drain, then a final clear
        repeat (3) drive(4'b0000, d, 1'b0);
        drive(4'b0000, d, 1'b1);
        repeat (2) drive(4'b0000, d, 1'b0);
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("final_q_zero", 32'(q), 32'd0);
`ifdef PIPO_ARB_STATS_EN
        chk("wr_cnt", 32'(wr_cnt), 32'((m_wr > 255) ? 255 : m_wr));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
